// File: rtl/vga_sprite_renderer.sv
// Two-stage pixel pipeline: 16x16 mono sprite over a live background, syncs re-timed to match RGB.
// Optional border overlay is enabled by defining VGA_BORDER_EN.
module vga_sprite_renderer #(
    parameter int          HLINES       = 640,
    parameter int          VLINES       = 480,
    parameter logic [11:0] SPRITE_COLOR = 12'hFFF,
    parameter logic [11:0] BORDER_COLOR = 12'hF00
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        blank,
    input  logic        hs,
    input  logic        vs,
    input  logic [10:0] sprite_x,
    input  logic [10:0] sprite_y,
    input  logic [11:0] bg_color,
    input  logic        bm_we,
    input  logic [3:0]  bm_addr,
    input  logic [15:0] bm_data,
    output logic [11:0] rgb,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic        frame_tick
);
    logic [10:0] r_sx, r_sy;
    logic        r_frame_tick;
    logic [15:0] r_bitmap [16];

    logic [15:0] r_row1;
    logic [3:0]  r_dx1;
    logic        r_hit1, r_blank1, r_hs1, r_vs1;

    logic [11:0] r_rgb;
    logic        r_hs2, r_vs2, r_blank2;

    logic [10:0] w_dx, w_dy;
    logic        w_hit, w_latch, w_pix;

    assign w_dx    = hcount - r_sx;
    assign w_dy    = vcount - r_sy;
    assign w_hit   = (w_dx < 11'd16) && (w_dy < 11'd16);
    assign w_latch = (hcount == 11'd0) && (vcount == 11'(VLINES));
    assign w_pix   = r_hit1 & r_row1[4'd15 - r_dx1];

`ifdef VGA_BORDER_EN
    logic r_border1;
    logic w_border;
    assign w_border = (hcount == 11'd0) || (hcount == 11'(HLINES - 1)) ||
                      (vcount == 11'd0) || (vcount == 11'(VLINES - 1));

    always_ff @(posedge pixel_clk) begin
        if (rst) r_border1 <= 1'b0;
        else     r_border1 <= w_border;
    end
`endif

    // Position is only taken at start of vertical blank so a frame never tears.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_sx         <= '0;
            r_sy         <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_latch;
            if (w_latch) begin
                r_sx <= sprite_x;
                r_sy <= sprite_y;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_bitmap[i] <= '0;
        end else if (bm_we) begin
            r_bitmap[bm_addr] <= bm_data;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_row1   <= '0;
            r_dx1    <= '0;
            r_hit1   <= 1'b0;
            r_blank1 <= 1'b1;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
        end else begin
            r_row1   <= r_bitmap[w_dy[3:0]];
            r_dx1    <= w_dx[3:0];
            r_hit1   <= w_hit;
            r_blank1 <= blank;
            r_hs1    <= hs;
            r_vs1    <= vs;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_rgb    <= '0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_blank2 <= 1'b1;
        end else begin
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_blank2 <= r_blank1;
            if (r_blank1)       r_rgb <= '0;
`ifdef VGA_BORDER_EN
            else if (r_border1) r_rgb <= BORDER_COLOR;
`endif
            else if (w_pix)     r_rgb <= SPRITE_COLOR;
            else                r_rgb <= bg_color;
        end
    end

    assign rgb        = r_rgb;
    assign hs_out     = r_hs2;
    assign vs_out     = r_vs2;
    assign blank_out  = r_blank2;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench: drives hcount/vcount directly (no full frames) and checks RGB, syncs and frame latch.
module tb_vga_sprite_renderer;
`ifdef VGA_BORDER_EN
    localparam bit BRD = 1'b1;
`else
    localparam bit BRD = 1'b0;
`endif
    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0, vcount = '0;
    logic        blank = 1'b1, hs = 1'b1, vs = 1'b1;
    logic [10:0] sprite_x = '0, sprite_y = '0;
    logic [11:0] bg_color = '0;
    logic        bm_we = 1'b0;
    logic [3:0]  bm_addr = '0;
    logic [15:0] bm_data = '0;
    logic [11:0] rgb;
    logic        hs_out, vs_out, blank_out, frame_tick;

    int errors = 0;
    int checks = 0;

    vga_sprite_renderer dut (
        .pixel_clk(pixel_clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .blank(blank), .hs(hs), .vs(vs), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .bg_color(bg_color), .bm_we(bm_we), .bm_addr(bm_addr), .bm_data(bm_data),
        .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
        .frame_tick(frame_tick)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one pixel position with 640x480 timing-derived blank/syncs, then clock once.
    task automatic drive(input int h, input int v);
        hcount = 11'(h);
        vcount = 11'(v);
        blank  = (h >= 640) || (v >= 480);
        hs     = !(h >= 656 && h < 752);
        vs     = !(v >= 490 && v < 492);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
        drive(h, v);
        drive(h, v);
        check(tag, {4'h0, rgb}, {4'h0, exp});
    endtask

    task automatic bm_write(input int row, input logic [15:0] data);
        bm_we   = 1'b1;
        bm_addr = 4'(row);
        bm_data = data;
        @(posedge pixel_clk);
        #1;
        bm_we = 1'b0;
    endtask

    task automatic latch();
        drive(0, 480);
        check("frame_tick_pulse", {15'h0, frame_tick}, 16'h1);
        drive(1, 480);
        check("frame_tick_single", {15'h0, frame_tick}, 16'h0);
    endtask

    initial begin
        // Reset: drive visible/sync-active inputs at the latch position; reset must dominate.
        hcount = 11'd0; vcount = 11'd480; blank = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("rst_rgb",   {4'h0, rgb}, 16'h0);
        check("rst_hs",    {15'h0, hs_out}, 16'h1);
        check("rst_vs",    {15'h0, vs_out}, 16'h1);
        check("rst_blank", {15'h0, blank_out}, 16'h1);
        check("rst_tick",  {15'h0, frame_tick}, 16'h0);
        rst = 1'b0;

        // Latency: blank then first visible pixel appears exactly 2 edges later.
        bg_color = 12'h00F;
        drive(700, 10);
        drive(700, 10);
        check("blank_rgb0", {4'h0, rgb}, 16'h0);
        drive(10, 10);
        check("lat_edge1", {4'h0, rgb}, 16'h0);
        drive(10, 10);
        check("lat_edge2", {4'h0, rgb}, 16'h00F);
        check("lat_blank_out", {15'h0, blank_out}, 16'h0);
        drive(660, 10);
        check("hs_edge1", {15'h0, hs_out}, 16'h1);
        drive(660, 10);
        check("hs_edge2", {15'h0, hs_out}, 16'h0);
        drive(10, 490);
        drive(10, 490);
        check("vs_delay2", {15'h0, vs_out}, 16'h0);

        // Sprite draw with a solid bitmap at (100,50).
        for (int r = 0; r < 16; r++) bm_write(r, 16'hFFFF);
        sprite_x = 11'd100; sprite_y = 11'd50;
        probe("pre_latch_miss", 100, 50, 12'h00F);
        drive(0, 479);
        check("no_tick_479", {15'h0, frame_tick}, 16'h0);
        latch();
        probe("spr_tl",   100, 50, 12'hFFF);
        probe("spr_br",   115, 65, 12'hFFF);
        probe("spr_l99",  99,  50, 12'h00F);
        probe("spr_r116", 116, 50, 12'h00F);
        probe("spr_v49",  100, 49, 12'h00F);
        probe("spr_v66",  100, 66, 12'h00F);

        // Individual bitmap bits, bit 15 = leftmost column.
        bm_write(0, 16'h8001);
        probe("bit_left",  100, 50, 12'hFFF);
        probe("bit_1",     101, 50, 12'h00F);
        probe("bit_14",    114, 50, 12'h00F);
        probe("bit_right", 115, 50, 12'hFFF);
        probe("row1_full", 101, 51, 12'hFFF);
        // Write to the row being read in the same cycle: read sees old contents.
        bm_we = 1'b1; bm_addr = 4'd0; bm_data = 16'hFFFF;
        drive(101, 50);
        bm_we = 1'b0;
        drive(101, 50);
        check("wr_rd_old", {4'h0, rgb}, 16'h00F);
        probe("wr_rd_new", 101, 50, 12'hFFF);

        // Tear-free: new position ignored until the next latch.
        drive(150, 200);
        sprite_x = 11'd200;
        probe("tear_old_hit",  100, 60, 12'hFFF);
        probe("tear_new_miss", 200, 60, 12'h00F);
        latch();
        probe("tear_new_hit",  200, 60, 12'hFFF);
        probe("tear_old_miss", 100, 60, 12'h00F);

        // Right-edge clip and horizontal wrap.
        sprite_x = 11'd630;
        latch();
        probe("clip_630",   630, 50, 12'hFFF);
        probe("clip_639",   639, 50, BRD ? 12'hF00 : 12'hFFF);
        probe("clip_blank", 640, 50, 12'h000);
        probe("wrap_0",     0,   50, BRD ? 12'hF00 : 12'h00F);
        probe("corner_00",  0,   0,  BRD ? 12'hF00 : 12'h00F);

        // Background is used live.
        bg_color = 12'h0F0;
        probe("bg_live", 300, 300, 12'h0F0);

        // Mid-frame reset takes effect on the next edge.
        drive(630, 50);
        rst = 1'b1;
        drive(630, 50);
        check("midrst_rgb", {4'h0, rgb}, 16'h0);
        check("midrst_blank", {15'h0, blank_out}, 16'h1);
        rst = 1'b0;
        probe("post_rst_bg", 630, 50, 12'h0F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
